// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data over fetch, with wait-state watchdog
module mem_arbiter #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ram_REN,
  output logic        ram_WEN,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, DACC, IACC, DRESP, IRESP} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, store_q;
  logic        wr_q;
  logic [7:0]  cnt;
  logic        dreq, acc, tout;
  assign dreq      = dREN | dWEN;
  assign acc       = state == DACC || state == IACC;
  assign tout      = cnt == 8'(TIMEOUT - 1);
  assign ram_REN   = state == IACC || (state == DACC && !wr_q);
  assign ram_WEN   = state == DACC && wr_q;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign ihit      = state == IRESP;
  assign dhit      = state == DRESP;
  // state register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nxt;
  // next state: data wins in IDLE, access ends on ready or watchdog expiry
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = dreq ? DACC : iREN ? IACC : IDLE;
      DACC:    nxt = (ram_ready || tout) ? DRESP : DACC;
      IACC:    nxt = (ram_ready || tout) ? IRESP : IACC;
      default: nxt = IDLE;
    endcase
  end
  // request capture, wait counter, returned words and sticky error
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      cnt     <= '0;
      iload   <= '0;
      dload   <= '0;
      err     <= 1'b0;
    end else if (state == IDLE && nxt != IDLE) begin
      addr_q  <= (dreq ? daddr : iaddr) & 32'hFFFF_FFFC;
      store_q <= dstore;
      wr_q    <= dWEN;
      cnt     <= '0;
    end else if (acc) begin
      if (ram_ready) begin
        if (state == IACC) iload <= ram_load;
        else if (!wr_q) dload <= ram_load;
      end else if (tout) begin
        err <= 1'b1;
        if (state == IACC) iload <= ERRWORD;
        else if (!wr_q) dload <= ERRWORD;
      end else cnt <= cnt + 8'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ram_load;
  logic        ihit, dhit, ram_REN, ram_WEN, err;
  logic [31:0] iload, dload, ram_addr, ram_store;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_arbiter #(.TIMEOUT(8), .ERRWORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
    .dload(dload), .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_load = 0;
    @(negedge CLK); @(negedge CLK);
    n_chk++;
    if ({ihit, dhit, ram_REN, ram_WEN, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {ihit, dhit, ram_REN, ram_WEN, err});
    end
    n_chk++;
    if ({iload, dload, ram_addr, ram_store} !== 128'h0) begin
      n_fail++; $display("FAIL reset_words got=%h exp=0", {iload, dload, ram_addr, ram_store});
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    dREN = 1; daddr = 32'h100;
    @(negedge CLK);
    n_chk++;
    if (ram_REN !== 1'b1 || ram_addr !== 32'h100) begin
      n_fail++; $display("FAIL mid_strobe got=%b/%h exp=1/00000100", ram_REN, ram_addr);
    end
    #2 nRST = 1'b0;
    #1;
    n_chk++;
    if ({ihit, dhit, ram_REN, ram_WEN, err} !== 5'b0 || ram_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_outs got=%b/%h exp=00000/0", {ihit, dhit, ram_REN, ram_WEN, err}, ram_addr);
    end
    dREN = 0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_chk++;
      if (dhit !== 1'b0 || ram_REN !== 1'b0) begin
        n_fail++; $display("FAIL mid_after got dhit=%b ren=%b exp=0/0", dhit, ram_REN);
      end
    end
  endtask

  task automatic test_fetch;
    iREN = 1; iaddr = 32'h0000_0043;
    @(negedge CLK);
    n_chk++;
    if (ram_REN !== 1'b1 || ram_WEN !== 1'b0 || ram_addr !== 32'h40) begin
      n_fail++; $display("FAIL fetch_strobe got=%b%b/%h exp=10/00000040", ram_REN, ram_WEN, ram_addr);
    end
    @(negedge CLK); @(negedge CLK);
    ram_ready = 1; ram_load = 32'h2402_0005;
    @(negedge CLK);
    ram_ready = 0; ram_load = 0;
    n_chk++;
    if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h2402_0005 || ram_REN !== 1'b0) begin
      n_fail++; $display("FAIL fetch_hit got=%b%b/%h/%b exp=10/24020005/0", ihit, dhit, iload, ram_REN);
    end
    iREN = 0;
    @(negedge CLK);
    n_chk++;
    if (ihit !== 1'b0 || iload !== 32'h2402_0005) begin
      n_fail++; $display("FAIL fetch_hold got=%b/%h exp=0/24020005", ihit, iload);
    end
  endtask

  task automatic test_priority;
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200;
    @(negedge CLK);
    n_chk++;
    if (ram_REN !== 1'b1 || ram_addr !== 32'h200) begin
      n_fail++; $display("FAIL prio_first got=%b/%h exp=1/00000200", ram_REN, ram_addr);
    end
    ram_ready = 1; ram_load = 32'h1111_2222;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h1111_2222) begin
      n_fail++; $display("FAIL prio_dhit got=%b%b/%h exp=10/11112222", dhit, ihit, dload);
    end
    dREN = 0;
    @(negedge CLK);
    n_chk++;
    if (ram_REN !== 1'b0 || dhit !== 1'b0) begin
      n_fail++; $display("FAIL prio_gap got=%b/%b exp=0/0", ram_REN, dhit);
    end
    @(negedge CLK);
    n_chk++;
    if (ram_REN !== 1'b1 || ram_addr !== 32'h300) begin
      n_fail++; $display("FAIL prio_fetch got=%b/%h exp=1/00000300", ram_REN, ram_addr);
    end
    ram_ready = 1; ram_load = 32'h3333_4444;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if (ihit !== 1'b1 || iload !== 32'h3333_4444) begin
      n_fail++; $display("FAIL prio_ihit got=%b/%h exp=1/33334444", ihit, iload);
    end
    iREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_store;
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_chk++;
    if (ram_WEN !== 1'b1 || ram_REN !== 1'b0 || ram_store !== 32'hDEAD_BEEF || ram_addr !== 32'h80) begin
      n_fail++; $display("FAIL store_strobe got=%b%b/%h/%h exp=10/deadbeef/00000080", ram_WEN, ram_REN, ram_store, ram_addr);
    end
    ram_ready = 1; ram_load = 32'hFFFF_FFFF;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if (dhit !== 1'b1 || ram_WEN !== 1'b0 || dload !== 32'h1111_2222) begin
      n_fail++; $display("FAIL store_hit got=%b/%b/%h exp=1/0/11112222", dhit, ram_WEN, dload);
    end
    dWEN = 0;
    @(negedge CLK);
    dREN = 1; dWEN = 1; daddr = 32'h87; dstore = 32'h0BAD_F00D;
    @(negedge CLK);
    n_chk++;
    if (ram_WEN !== 1'b1 || ram_REN !== 1'b0 || ram_addr !== 32'h84 || ram_store !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL both_write got=%b%b/%h/%h exp=10/00000084/0badf00d", ram_WEN, ram_REN, ram_addr, ram_store);
    end
    ram_ready = 1;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if (dhit !== 1'b1 || dload !== 32'h1111_2222) begin
      n_fail++; $display("FAIL both_hit got=%b/%h exp=1/11112222", dhit, dload);
    end
    dREN = 0; dWEN = 0;
    @(negedge CLK);
  endtask

  task automatic test_timeout;
    int n;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_before got=%b exp=0", err);
    end
    dREN = 1; daddr = 32'h44;
    @(negedge CLK);
    n = 0;
    while (ram_REN && n < 20) begin
      n++;
      @(negedge CLK);
    end
    n_chk++;
    if (n !== 8) begin
      n_fail++; $display("FAIL tout_len got=%0d exp=8", n);
    end
    n_chk++;
    if (dhit !== 1'b1 || dload !== 32'hBAD1BAD1 || err !== 1'b1) begin
      n_fail++; $display("FAIL tout_hit got=%b/%h/%b exp=1/bad1bad1/1", dhit, dload, err);
    end
    dREN = 0;
    @(negedge CLK);
    iREN = 1; iaddr = 32'h10;
    @(negedge CLK);
    ram_ready = 1; ram_load = 32'h5555_6666;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if (ihit !== 1'b1 || iload !== 32'h5555_6666 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky got=%b/%h/%b exp=1/55556666/1", ihit, iload, err);
    end
    iREN = 0;
    @(negedge CLK);
  endtask

  task automatic test_stray;
    ram_ready = 1; ram_load = 32'h7777_7777;
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if ({ihit, dhit, ram_REN, ram_WEN} !== 4'b0 || dload !== 32'hBAD1BAD1 || iload !== 32'h5555_6666) begin
      n_fail++; $display("FAIL stray_idle got=%b/%h/%h exp=0000/bad1bad1/55556666", {ihit, dhit, ram_REN, ram_WEN}, dload, iload);
    end
    dREN = 1; daddr = 32'h20;
    @(negedge CLK);
    ram_ready = 1; ram_load = 32'h8888_9999;
    @(negedge CLK);
    dREN = 0; ram_load = 32'hAAAA_BBBB;
    n_chk++;
    if (dhit !== 1'b1 || dload !== 32'h8888_9999) begin
      n_fail++; $display("FAIL stray_dhit got=%b/%h exp=1/88889999", dhit, dload);
    end
    @(negedge CLK);
    ram_ready = 0;
    n_chk++;
    if ({ihit, dhit, ram_REN, ram_WEN} !== 4'b0 || dload !== 32'h8888_9999) begin
      n_fail++; $display("FAIL stray_resp got=%b/%h exp=0000/88889999", {ihit, dhit, ram_REN, ram_WEN}, dload);
    end
    @(negedge CLK);
    n_chk++;
    if ({ihit, dhit, ram_REN, ram_WEN} !== 4'b0) begin
      n_fail++; $display("FAIL stray_after got=%b exp=0000", {ihit, dhit, ram_REN, ram_WEN});
    end
  endtask

  task automatic test_err_clear;
    nRST = 1'b0;
    #1;
    n_chk++;
    if (err !== 1'b0 || dload !== 32'h0 || iload !== 32'h0) begin
      n_fail++; $display("FAIL err_clear got=%b/%h/%h exp=0/0/0", err, dload, iload);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_fetch;
    test_priority;
    test_store;
    test_timeout;
    test_stray;
    test_err_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined CPU: merges the instruction-fetch request and the data (load/store) request from the pipeline latches onto one RAM port and returns the `ihit`/`dhit` completion pulses that advance or stall those latches. Data requests have fixed priority over fetches. A wait-state watchdog bounds every access and reports a stuck RAM.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent waiting for `ram_ready` before an access is force-completed (valid range 2..255).
- ERRWORD, 32'hBAD1BAD1: load value returned on a timed-out read.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction fetch request, level, held until `ihit`.
- iaddr  in  32  fetch byte address.
- dREN  in  1  data read request, level, held until `dhit`.
- dWEN  in  1  data write request, level, held until `dhit`.
- daddr  in  32  data byte address.
- dstore  in  32  write data.
- ihit  out  1  one-cycle fetch completion pulse.
- iload  out  32  fetched word, valid while `ihit`=1.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  32  load word, valid while `dhit`=1.
- ram_REN  out  1  RAM read strobe.
- ram_WEN  out  1  RAM write strobe.
- ram_addr  out  32  RAM byte address, bits [1:0] always 0.
- ram_store  out  32  RAM write data.
- ram_load  in  32  RAM read data, sampled when `ram_ready`=1.
- ram_ready  in  1  RAM completion, one cycle.
- err  out  1  sticky: at least one access timed out since reset.

## Operation
- States: IDLE, DACC, IACC, DRESP, IRESP.
- IDLE: if `dREN|dWEN` -> DACC; else if `iREN` -> IACC; else stay. On entry to DACC/IACC, capture address ({addr[31:2],2'b00}), `dstore`, and op (write if `dWEN`, else read); clear wait counter.
- `dREN` and `dWEN` both high: treated as write.
- DACC/IACC: drive `ram_REN` or `ram_WEN` from captured op (IACC always read), `ram_addr`/`ram_store` from captured registers. Requester inputs ignored here (no abort). On `ram_ready`: capture `ram_load` into `dload`/`iload`, go DRESP/IRESP. Else increment counter; when counter reaches TIMEOUT-1 without `ram_ready`: load ERRWORD (reads), set `err`, go DRESP/IRESP.
- DRESP: `dhit`=1, `dload` valid; -> IDLE. IRESP: `ihit`=1, `iload` valid; -> IDLE.
- `ihit` and `dhit` never high in the same cycle. Strobes low in IDLE/RESP states.
- `dload`/`iload` hold their last value outside hit cycles. Writes leave `dload` unchanged.
- Fixed priority: a continuously asserted data request starves fetches (pipeline guarantees data requests drop after `dhit`).

## Timing
- Reset (async, any state, mid-access included): state IDLE, all outputs 0 (`ihit`,`dhit`,`iload`,`dload`,`ram_*`,`err`), counter 0. The in-flight access is dropped; no hit issued.
- Request high in IDLE at cycle N -> strobe high from cycle N+1.
- `ram_ready` high in cycle M (M>=N+1) -> hit pulse in cycle M+1; strobes drop in M+1.
- Minimum request-to-hit: 2 cycles; back-to-back accesses: hit at M+1, IDLE at M+2, next strobe at M+3.
- Timeout: strobe held exactly TIMEOUT cycles, hit on the following cycle; `err` rises with the hit and stays until reset.
- `ram_ready` while not in DACC/IACC is ignored.
- Hit outputs are registered-state decodes (glitch-free, no combinational path from `ram_ready` to hits).

## Test plan
- Reset mid-access: start data read at 0x100, assert nRST=0 while `ram_REN`=1 -> all outputs 0 immediately; after release, no `dhit`, state IDLE.
- Single fetch: iREN=1, iaddr=0x0000_0043, RAM ready after 3 cycles with 0x2402_0005 -> `ram_addr`=0x40, `ihit` pulse 1 cycle later, `iload`=0x2402_0005.
- Priority: iREN and dREN high at cycle N, daddr=0x200 -> data access first (`dhit` with RAM word), fetch strobe begins 2 cycles after `dhit`, `ihit` follows.
- Store: dWEN=1, daddr=0x80, dstore=0xDEAD_BEEF, immediate ready -> `ram_WEN`=1, `ram_store`=0xDEAD_BEEF for 1 cycle, `dhit` next cycle, `dload` unchanged.
- Timeout: TIMEOUT=8, dREN=1, ram_ready held 0 -> `ram_REN` high exactly 8 cycles, then `dhit`=1, `dload`=0xBAD1BAD1, `err`=1 sticky across later good accesses.
- Stray ready: ram_ready pulsed in IDLE and during DRESP -> no state change, no extra hit.
